// File: rtl/dist_seq_controller_pkg.sv
// Shared encodings for the distance sequencer: FSM state codes and BRAM strobe patterns.
package dist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_HARD_RESET = 3'd1;
  localparam state_t ST_FETCH      = 3'd2;
  localparam state_t ST_WAIT_ACC   = 3'd3;
  localparam state_t ST_SOFT_RESET = 3'd4;
  localparam state_t ST_WAIT_SQRT  = 3'd5;
  localparam state_t ST_WRITE      = 3'd6;
  localparam state_t ST_DONE       = 3'd7;

  // FLAG_Bram is {cs, we, oe}
  localparam logic [2:0] BRAM_IDLE = 3'b000;
  localparam logic [2:0] BRAM_RD   = 3'b101;
  localparam logic [2:0] BRAM_WR   = 3'b110;

endpackage

// File: rtl/dist_seq_controller_if.sv
// Host, accumulator, sqrt and BRAM signals of the distance sequencer.
// master is the sequencer side, slave is the surrounding datapath/host.
interface dist_seq_controller_if #(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10,
  parameter int LANES  = 1
);
  logic              STARTCALC;
  logic              ABORT;
  logic [CNT_W-1:0]  NUM_OF_VECTORS;
  logic [CNT_W-1:0]  VECTOR_WIDTH;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [ADDR_W-1:0] RES_ADDR;
  logic              RDY_Acc;
  logic              RDY_Sqrt;
  logic              EN_Acc;
  logic              RST_Acc;
  logic              PRE_Acc;
  logic              EN_Sqrt;
  logic [ADDR_W-1:0] ADDR_Bram;
  logic [2:0]        FLAG_Bram;
  logic [LANES-1:0]  LANE_MASK;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  STARTCALC, ABORT, NUM_OF_VECTORS, VECTOR_WIDTH, BASE_ADDR, RES_ADDR,
           RDY_Acc, RDY_Sqrt,
    output EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, FLAG_Bram, LANE_MASK,
           BUSY, DONE
  );

  modport slave (
    output STARTCALC, ABORT, NUM_OF_VECTORS, VECTOR_WIDTH, BASE_ADDR, RES_ADDR,
           RDY_Acc, RDY_Sqrt,
    input  EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, ADDR_Bram, FLAG_Bram, LANE_MASK,
           BUSY, DONE
  );
endinterface

// File: rtl/dist_seq_controller_addr_gen.sv
// Address and index bookkeeping for the sequencer: latched config, read pointer,
// element/vector indices, lane mask and the last-pass / last-vector compares.
module dist_addr_gen
  import dist_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step_elem,
  input  logic              step_vec,
  input  logic              clear,
  input  logic [CNT_W-1:0]  num_in,
  input  logic [CNT_W-1:0]  width_in,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] res_in,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LANES-1:0]  lane_mask,
  output logic              last_pass,
  output logic              last_vec
);

  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  width_q;
  logic [ADDR_W-1:0] res_q;
  logic [CNT_W:0]    elem_idx;
  logic [CNT_W-1:0]  vec_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q    <= '0;
      width_q  <= '0;
      res_q    <= '0;
      rd_ptr   <= '0;
      elem_idx <= '0;
      vec_idx  <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      elem_idx <= '0;
      vec_idx  <= '0;
    end else if (load) begin
      num_q    <= num_in;
      width_q  <= width_in;
      res_q    <= res_in;
      rd_ptr   <= base_in;
      elem_idx <= '0;
      vec_idx  <= '0;
    end else begin
      if (step_elem) begin
        elem_idx <= elem_idx + (CNT_W+1)'(LANES);
        rd_ptr   <= rd_ptr + ADDR_W'(LANES);
      end
      // rd_ptr keeps running into the next vector; only the element index restarts
      if (step_vec) begin
        vec_idx  <= vec_idx + 1'b1;
        elem_idx <= '0;
      end
    end
  end

  // one guard bit above elem_idx so elem_idx+LANES never wraps
  assign last_pass = ({1'b0, elem_idx} + (CNT_W+2)'(LANES)) >= (CNT_W+2)'(width_q);
  assign last_vec  = (vec_idx == num_q - CNT_W'(1));
  assign wr_addr   = res_q + ADDR_W'(vec_idx);

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = ({1'b0, elem_idx} + (CNT_W+2)'(i)) < (CNT_W+2)'(width_q);
    end
  end

endmodule

// File: rtl/dist_seq_controller.sv
// Multi-vector distance sequencer: fetches elements LANES at a time, steps the
// accumulator through hard/soft resets, waits on sqrt and writes each result back.
//
// state       | meaning
// IDLE        | waiting for STARTCALC, config latched on start
// HARD_RESET  | clear accumulator for a new vector
// FETCH       | BRAM read of up to LANES elements at rd_ptr
// WAIT_ACC    | wait for the accumulator pass to finish
// SOFT_RESET  | reset accumulator stage, keeping the running sum
// WAIT_SQRT   | sqrt working on the finished sum
// WRITE       | BRAM write of the result at RES_ADDR+vec_idx
// DONE        | one-cycle completion pulse
module dist_seq_controller
  import dist_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10,
  parameter int LANES  = 1
) (
  input logic clk,
  input logic rst,
  dist_seq_controller_if.master bus
);

  state_t            state_q, state_d;
  logic              load, step_elem, step_vec, clear;
  logic [ADDR_W-1:0] rd_ptr, wr_addr;
  logic [LANES-1:0]  lane_mask;
  logic              last_pass, last_vec;

  dist_addr_gen #(
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W),
    .LANES (LANES)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step_elem(step_elem),
    .step_vec (step_vec),
    .clear    (clear),
    .num_in   (bus.NUM_OF_VECTORS),
    .width_in (bus.VECTOR_WIDTH),
    .base_in  (bus.BASE_ADDR),
    .res_in   (bus.RES_ADDR),
    .rd_ptr   (rd_ptr),
    .wr_addr  (wr_addr),
    .lane_mask(lane_mask),
    .last_pass(last_pass),
    .last_vec (last_vec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step_elem = 1'b0;
    step_vec  = 1'b0;
    clear     = 1'b0;
    // abort takes priority over any ready arriving in the same cycle
    if (state_q != ST_IDLE && bus.ABORT) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.STARTCALC) begin
            load    = 1'b1;
            state_d = (bus.NUM_OF_VECTORS == '0 || bus.VECTOR_WIDTH == '0) ? ST_DONE
                                                                            : ST_HARD_RESET;
          end
        end
        ST_HARD_RESET: state_d = ST_FETCH;
        ST_FETCH:      state_d = ST_WAIT_ACC;
        ST_WAIT_ACC: begin
          if (bus.RDY_Acc) begin
            step_elem = 1'b1;
            state_d   = last_pass ? ST_WAIT_SQRT : ST_SOFT_RESET;
          end
        end
        ST_SOFT_RESET: state_d = ST_FETCH;
        ST_WAIT_SQRT: begin
          if (bus.RDY_Sqrt) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (last_vec) begin
            state_d = ST_DONE;
          end else begin
            step_vec = 1'b1;
            state_d  = ST_HARD_RESET;
          end
        end
        ST_DONE: begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.EN_Acc    = 1'b0;
    bus.RST_Acc   = 1'b0;
    bus.PRE_Acc   = 1'b0;
    bus.EN_Sqrt   = 1'b0;
    bus.ADDR_Bram = '0;
    bus.FLAG_Bram = BRAM_IDLE;
    bus.LANE_MASK = '0;
    bus.BUSY      = (state_q != ST_IDLE);
    bus.DONE      = 1'b0;
    case (state_q)
      ST_HARD_RESET: begin
        bus.EN_Acc  = 1'b1;
        bus.RST_Acc = 1'b1;
      end
      ST_FETCH: begin
        bus.EN_Acc    = 1'b1;
        bus.FLAG_Bram = BRAM_RD;
        bus.ADDR_Bram = rd_ptr;
        bus.LANE_MASK = lane_mask;
      end
      ST_WAIT_ACC: bus.EN_Acc = 1'b1;
      ST_SOFT_RESET: begin
        bus.EN_Acc  = 1'b1;
        bus.RST_Acc = 1'b1;
        bus.PRE_Acc = 1'b1;
      end
      ST_WAIT_SQRT: begin
        bus.EN_Acc  = 1'b1;
        bus.EN_Sqrt = 1'b1;
      end
      ST_WRITE: begin
        bus.FLAG_Bram = BRAM_WR;
        bus.ADDR_Bram = wr_addr;
      end
      ST_DONE: bus.DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/dist_seq_controller.md
Name: dist_seq_controller

Overview:
Parametrised successor to the distance control unit. It sequences multi-vector distance computation: it fetches each vector's elements from BRAM LANES at a time, drives the accumulator through hard and soft resets, hands each finished sum to the square-root unit, and writes each result back to BRAM. It sits between the host start logic and the accumulator, sqrt and BRAM datapath. Compared with the previous unit it adds real address generation, multi-lane passes with partial-pass masking, result write-back, DONE/BUSY/ABORT handshakes, exact vector counting and a defined reset.

Parameters:
CNT_W, 8, width of the vector-count and vector-width inputs and their internal counters
ADDR_W, 10, BRAM address width
LANES, 1, elements consumed per accumulator pass (1..8)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
STARTCALC  in  1  start request; sampled only in IDLE
ABORT  in  1  synchronous abort; returns the block to IDLE
NUM_OF_VECTORS  in  CNT_W  number of vectors to process; latched at start
VECTOR_WIDTH  in  CNT_W  elements per vector; latched at start
BASE_ADDR  in  ADDR_W  BRAM address of element 0 of vector 0; latched at start
RES_ADDR  in  ADDR_W  BRAM address for result 0; latched at start
RDY_Acc  in  1  accumulator pass complete
RDY_Sqrt  in  1  sqrt result valid
EN_Acc  out  1  accumulator enable
RST_Acc  out  1  accumulator reset
PRE_Acc  out  1  preserve the running sum on reset
EN_Sqrt  out  1  sqrt enable
ADDR_Bram  out  ADDR_W  BRAM address
FLAG_Bram  out  3  {cs,we,oe}
LANE_MASK  out  LANES  valid lanes for the current fetch
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle completion pulse

Behaviour:
- Outputs are Moore, decoded from the registered state plus counters. No output is ever X; PRE_Acc is 0 wherever it is not listed below.
- Async reset: state IDLE, vec_idx=0, elem_idx=0, rd_ptr=0. All outputs 0, FLAG_Bram=3'b000, LANE_MASK=0.
- IDLE:
  - STARTCALC=1 latches the four config inputs and rd_ptr=BASE_ADDR.
  - Next state is DONE if NUM_OF_VECTORS==0 or VECTOR_WIDTH==0; otherwise HARD_RESET.
- HARD_RESET (1 cycle): EN_Acc=1, RST_Acc=1, PRE_Acc=0; elem_idx<=0.
- FETCH (1 cycle):
  - FLAG_Bram=3'b101, ADDR_Bram=rd_ptr, EN_Acc=1.
  - LANE_MASK has bit i set when elem_idx+i < VECTOR_WIDTH.
- WAIT_ACC: EN_Acc=1; hold until RDY_Acc=1. On RDY_Acc:
  - elem_idx += LANES; rd_ptr += LANES.
  - If old elem_idx+LANES >= VECTOR_WIDTH, go to WAIT_SQRT; otherwise go to SOFT_RESET.
- SOFT_RESET (1 cycle): EN_Acc=1, RST_Acc=1, PRE_Acc=1; then FETCH.
- WAIT_SQRT: EN_Acc=1, EN_Sqrt=1; hold until RDY_Sqrt=1, then WRITE.
- WRITE (1 cycle): FLAG_Bram=3'b110, ADDR_Bram=RES_ADDR+vec_idx (mod 2^ADDR_W).
  - If vec_idx==NUM_OF_VECTORS-1, go to DONE.
  - Otherwise vec_idx++ and go to HARD_RESET.
- DONE (1 cycle): DONE=1, BUSY=1; clear vec_idx, elem_idx, rd_ptr; then IDLE.
- The total pass count per vector is ceil(VECTOR_WIDTH/LANES). Exactly NUM_OF_VECTORS results are written.
- rd_ptr runs contiguously across vectors: vector k starts at BASE_ADDR + k*VECTOR_WIDTH rounded up to a multiple of LANES. Addresses wrap modulo 2^ADDR_W with no flag.
- Counter widths: elem_idx is CNT_W+1 bits so the comparison cannot overflow.
- Ignored inputs:
  - STARTCALC outside IDLE has no effect.
  - Changes to the config inputs after latching have no effect.
  - RDY_Acc outside WAIT_ACC and RDY_Sqrt outside WAIT_SQRT are ignored.
- Response latency:
  - RDY_Acc held continuously: minimum 3 cycles per pass (FETCH, WAIT_ACC, SOFT_RESET).
  - START to first FETCH: 2 cycles.
- ABORT=1 in any non-IDLE state: next state IDLE, counters cleared, no DONE pulse. ABORT wins over RDY_Acc or RDY_Sqrt arriving in the same cycle.
- rst mid-operation forces IDLE immediately (asynchronously), with outputs at their reset values.

Decomposition:
- Package dist_pkg holds:
  - the state encoding (localparams ST_IDLE..ST_DONE, 3 bits);
  - FLAG_Bram constants BRAM_IDLE=3'b000, BRAM_RD=3'b101, BRAM_WR=3'b110.
- One sub-module, dist_addr_gen, holds rd_ptr, elem_idx, vec_idx, LANE_MASK and the last-pass/last-vector compares. It is driven by load/step_elem/step_vec/clear strobes from the FSM.

Test Plan:
- LANES=1, N=2, W=4, BASE=0x010, RES=0x200, RDY_Acc 2 cycles after each FETCH, RDY_Sqrt 3 cycles after entry -> read addresses 0x010..0x017; writes at 0x200 then 0x201; DONE pulses once; exactly 2 hard resets and 6 PRE_Acc=1 soft resets.
- LANES=4, N=1, W=6, RDY_Acc tied high -> two FETCHes at BASE, BASE+4 with LANE_MASK 4'b1111 then 4'b0011; one write; DONE 11 cycles after STARTCALC.
- N=0 (and separately W=0) -> DONE pulse the cycle after the start cycle; FLAG_Bram stays 000 throughout; BUSY high for 1 cycle.
- ABORT asserted in the 2nd WAIT_ACC cycle coincident with RDY_Acc=1 -> IDLE next cycle; no SOFT_RESET, write or DONE; a subsequent STARTCALC restarts from BASE_ADDR.
- rst pulsed during WAIT_SQRT -> all outputs 0 before the next clk edge; block stays IDLE until a new STARTCALC.
- STARTCALC held high through a whole N=1 run while NUM_OF_VECTORS changes mid-run -> exactly one result written; a new run starts one cycle after DONE.
